// File: rtl/demux2bit1to3_reg.sv
// -----------------------------------------------------------------------------
// demux2bit1to3_reg
//   Registered 1-to-3 demultiplexer. This is the write-side partner of the
//   2-bit 3-to-1 select mux. A WIDTH-bit word is routed into one of three
//   holding registers (U, V, W) when Load rises. The channel is taken from S
//   in manual mode, or from a round-robin pointer in auto mode. Sticky valid
//   and overwrite flags are kept for each channel.
//
// Ports
//   Clock   in   1      system clock, rising-edge active
//   Resetn  in   1      asynchronous active-low reset
//   D       in   WIDTH  data word to route
//   S       in   2      manual channel select (00->U, 10->V, x1->W)
//   Load    in   1      write strobe (level); one write per rising edge
//   Auto    in   1      0 = manual select, 1 = round-robin pointer
//   Clear   in   1      synchronous clear of registers, flags and pointer
//   U/V/W   out  WIDTH  channel 0/1/2 holding registers
//   Valid   out  3      sticky written flags {W,V,U}
//   Ovf     out  3      sticky overwrite flags {W,V,U}
//   Ptr     out  2      round-robin pointer (0..2)
// -----------------------------------------------------------------------------
module demux2bit1to3_reg #(
    parameter int WIDTH = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       S,
    input  logic             Load,
    input  logic             Auto,
    input  logic             Clear,
    output logic [WIDTH-1:0] U,
    output logic [WIDTH-1:0] V,
    output logic [WIDTH-1:0] W,
    output logic [2:0]       Valid,
    output logic [2:0]       Ovf,
    output logic [1:0]       Ptr
);

    // One-hot target channel. In manual mode S[0] has priority and selects W.
    // In auto mode an out-of-range pointer (3) is treated as channel 0.
    function automatic logic [2:0] decode_target(input logic       auto_i,
                                                 input logic [1:0] sel_i,
                                                 input logic [1:0] ptr_i);
        logic [2:0] onehot;
        if (auto_i) begin
            case (ptr_i)
                2'd1:    onehot = 3'b010;
                2'd2:    onehot = 3'b100;
                default: onehot = 3'b001;
            endcase
        end else begin
            if (sel_i[0]) begin
                onehot = 3'b100;
            end else if (sel_i[1]) begin
                onehot = 3'b010;
            end else begin
                onehot = 3'b001;
            end
        end
        return onehot;
    endfunction

    // Pointer sequence 0->1->2->0. A stray value of 3 behaves like 0, so it
    // steps to 1.
    function automatic logic [1:0] ptr_advance(input logic [1:0] ptr_i);
        logic [1:0] nxt;
        case (ptr_i)
            2'd1:    nxt = 2'd2;
            2'd2:    nxt = 2'd0;
            default: nxt = 2'd1;
        endcase
        return nxt;
    endfunction

    logic [WIDTH-1:0] u_r, v_r, w_r;
    logic [2:0]       valid_r, ovf_r;
    logic [1:0]       ptr_r;
    logic             load_q_r;

    logic [WIDTH-1:0] u_s, v_s, w_s;
    logic [2:0]       valid_s, ovf_s;
    logic [1:0]       ptr_s;
    logic             write_s;
    logic [2:0]       target_s;

    // Write event is the rising edge of Load, seen against last cycle's Load.
    assign write_s  = Load & ~load_q_r;
    assign target_s = decode_target(Auto, S, ptr_r);

    // Next-state computation: Clear wins over a coincident write event.
    always_comb begin
        u_s     = u_r;
        v_s     = v_r;
        w_s     = w_r;
        valid_s = valid_r;
        ovf_s   = ovf_r;
        ptr_s   = ptr_r;
        if (Clear) begin
            u_s     = '0;
            v_s     = '0;
            w_s     = '0;
            valid_s = 3'b000;
            ovf_s   = 3'b000;
            ptr_s   = 2'd0;
        end else if (write_s) begin
            if (target_s[0]) begin
                u_s = D;
            end else begin
                u_s = u_r;
            end
            if (target_s[1]) begin
                v_s = D;
            end else begin
                v_s = v_r;
            end
            if (target_s[2]) begin
                w_s = D;
            end else begin
                w_s = w_r;
            end
            // A write to an already-valid channel flags an overwrite.
            ovf_s   = ovf_r | (target_s & valid_r);
            valid_s = valid_r | target_s;
            if (Auto) begin
                ptr_s = ptr_advance(ptr_r);
            end else begin
                ptr_s = ptr_r;
            end
        end else begin
            ptr_s = ptr_r;
        end
    end

    // State registers. Load history updates even while Clear is active, so
    // Load held high through Clear gives no write afterwards.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            u_r      <= '0;
            v_r      <= '0;
            w_r      <= '0;
            valid_r  <= 3'b000;
            ovf_r    <= 3'b000;
            ptr_r    <= 2'd0;
            load_q_r <= 1'b0;
        end else begin
            u_r      <= u_s;
            v_r      <= v_s;
            w_r      <= w_s;
            valid_r  <= valid_s;
            ovf_r    <= ovf_s;
            ptr_r    <= ptr_s;
            load_q_r <= Load;
        end
    end

    assign U     = u_r;
    assign V     = v_r;
    assign W     = w_r;
    assign Valid = valid_r;
    assign Ovf   = ovf_r;
    assign Ptr   = ptr_r;

endmodule

// File: tb/tb_demux2bit1to3_reg.sv
module tb_demux2bit1to3_reg;

    logic       clk;
    logic       rst_n;
    logic [1:0] d;
    logic [1:0] s;
    logic       load;
    logic       auto_m;
    logic       clear;
    logic [1:0] u, v, w;
    logic [2:0] valid, ovf;
    logic [1:0] ptr;

    int total;
    int bad;

    typedef struct {
        logic       clr;
        logic       ld;
        logic       au;
        logic [1:0] s;
        logic [1:0] d;
        logic [1:0] eu;
        logic [1:0] ev;
        logic [1:0] ew;
        logic [2:0] eval;
        logic [2:0] eovf;
        logic [1:0] eptr;
    } vec_t;

    vec_t vecs[$];

    demux2bit1to3_reg #(.WIDTH(2)) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .D      (d),
        .S      (s),
        .Load   (load),
        .Auto   (auto_m),
        .Clear  (clear),
        .U      (u),
        .V      (v),
        .W      (w),
        .Valid  (valid),
        .Ovf    (ovf),
        .Ptr    (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic clr, input logic ld, input logic au,
                       input logic [1:0] sv, input logic [1:0] dv,
                       input logic [1:0] eu, input logic [1:0] ev,
                       input logic [1:0] ew, input logic [2:0] eval,
                       input logic [2:0] eovf, input logic [1:0] eptr);
        vec_t r;
        r.clr = clr; r.ld = ld; r.au = au; r.s = sv; r.d = dv;
        r.eu = eu; r.ev = ev; r.ew = ew; r.eval = eval; r.eovf = eovf;
        r.eptr = eptr;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = {u, v, w, valid, ovf, ptr};
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got u=%b v=%b w=%b valid=%b ovf=%b ptr=%0d, expected u=%b v=%b w=%b valid=%b ovf=%b ptr=%0d",
                     name, act[13:12], act[11:10], act[9:8], act[7:5], act[4:2], act[1:0],
                     exp[13:12], exp[11:10], exp[9:8], exp[7:5], exp[4:2], exp[1:0]);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // clr ld au  s      d      u      v      w      valid   ovf     ptr
        // manual routing
        add(1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000, 2'd0);
        add(1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000, 2'd0);
        add(1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 3'b011, 3'b000, 2'd0);
        add(1'b0, 1'b0, 1'b0, 2'b01, 2'b11, 2'b01, 2'b10, 2'b00, 3'b011, 3'b000, 2'd0);
        add(1'b0, 1'b1, 1'b0, 2'b01, 2'b11, 2'b01, 2'b10, 2'b11, 3'b111, 3'b000, 2'd0);
        add(1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 3'b111, 3'b000, 2'd0);
        add(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 3'b111, 3'b100, 2'd0);
        // clear, then Load held high for 5 cycles with changing D
        add(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'd0);
        add(1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 3'b010, 3'b000, 2'd0);
        add(1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 3'b010, 3'b000, 2'd0);
        add(1'b0, 1'b1, 1'b0, 2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 3'b010, 3'b000, 2'd0);
        add(1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 3'b010, 3'b000, 2'd0);
        add(1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 3'b010, 3'b000, 2'd0);
        add(1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 3'b010, 3'b000, 2'd0);
        // auto mode: four pulses, S ignored
        add(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'd0);
        add(1'b0, 1'b1, 1'b1, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000, 2'd1);
        add(1'b0, 1'b0, 1'b1, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000, 2'd1);
        add(1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 3'b011, 3'b000, 2'd2);
        add(1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 3'b011, 3'b000, 2'd2);
        add(1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 3'b111, 3'b000, 2'd0);
        add(1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 3'b111, 3'b000, 2'd0);
        add(1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 3'b111, 3'b001, 2'd1);
        add(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 3'b111, 3'b001, 2'd1);
        // Clear and Load rise together with Ptr=1, Load then held high
        add(1'b1, 1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'd0);
        add(1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'd0);
        add(1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'd0);
        add(1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'd0);
        // reach Ptr=2, switch to manual, write U, back to auto, write W
        add(1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000, 2'd1);
        add(1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000, 2'd1);
        add(1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 3'b011, 3'b000, 2'd2);
        add(1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 3'b011, 3'b000, 2'd2);
        add(1'b0, 1'b1, 1'b0, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00, 3'b011, 3'b001, 2'd2);
        add(1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00, 3'b011, 3'b001, 2'd2);
        add(1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 3'b111, 3'b001, 2'd0);
        add(1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 3'b111, 3'b001, 2'd0);
        // Auto drops to 0 on the same edge as the Load rise: manual decides
        add(1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b11, 2'b10, 2'b01, 3'b111, 3'b011, 2'd0);
        add(1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b11, 2'b10, 2'b01, 3'b111, 3'b011, 2'd0);

        rst_n  = 1'b0;
        d      = 2'b00;
        s      = 2'b00;
        load   = 1'b0;
        auto_m = 1'b0;
        clear  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_state", 14'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clear  = vecs[i].clr;
            load   = vecs[i].ld;
            auto_m = vecs[i].au;
            s      = vecs[i].s;
            d      = vecs[i].d;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {vecs[i].eu, vecs[i].ev, vecs[i].ew, vecs[i].eval,
                   vecs[i].eovf, vecs[i].eptr});
        end

        // asynchronous reset mid-cycle with U=11: outputs clear before any edge
        @(negedge clk);
        check("pre_async_reset", {2'b11, 2'b10, 2'b01, 3'b111, 3'b011, 2'd0});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 14'b0);

        // Load already high when reset releases: first edge is a write
        load   = 1'b1;
        auto_m = 1'b0;
        s      = 2'b00;
        d      = 2'b10;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("released_no_edge", 14'b0);
        @(posedge clk);
        #1;
        check("load_after_reset", {2'b10, 2'b00, 2'b00, 3'b001, 3'b000, 2'd0});
        @(posedge clk);
        #1;
        check("load_held_after_reset", {2'b10, 2'b00, 2'b00, 3'b001, 3'b000, 2'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
